// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    // Capture FSM encoding
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_LOW = 2'd2
    } cap_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word fall-through read.
// Push and pop can happen on the same edge. This is allowed even when the FIFO
// is full, because the pop frees the slot that the push writes.
module sync_fifo
    import uart_pkg::*;
#(
    parameter  int DATA_W = UART_DATA_W,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_en;
    logic              rd_en;

    assign full  = (count == (ADDR_W + 1)'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;
    assign rdata = mem[rd_ptr];

    // Storage array: no reset, since contents are only visible while count > 0.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ADDR_W'(wr_ptr + 1'b1);
            end
            if (rd_en) begin
                rd_ptr <= ADDR_W'(rd_ptr + 1'b1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver. Each byte is captured
// exactly once, acknowledged with a one-cycle rx_clr pulse, and queued for the
// consumer.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for rx_ready; captures (or drops) the byte
// ACK      | rx_clr asserted for exactly this one cycle
// WAIT_LOW | waiting for receiver to drop rx_ready before re-arming
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DATA_W = UART_DATA_W,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_ready,
    output logic              rx_clr,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    input  logic              ovf_clr
);

    cap_state_t state;
    cap_state_t state_nxt;
    logic       capture;
    logic       pop;
    logic       push;
    logic       drop;

    assign m_valid = ~empty;
    assign pop     = m_valid & m_ready;
    assign capture = (state == IDLE) & rx_ready;
    // A full FIFO still takes the byte if the consumer frees a slot on this edge.
    assign push    = capture & (~full | pop);
    assign drop    = capture & full & ~pop;
    assign rx_clr  = (state == ACK);

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (rx_data),
        .pop   (pop),
        .rdata (m_data),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Next-state logic for the capture FSM.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (rx_ready) state_nxt = ACK;
            ACK:      state_nxt = WAIT_LOW;
            WAIT_LOW: if (!rx_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Capture FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Sticky overflow flag. A drop on the same edge as ovf_clr keeps it set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo. It models the receiver side, which holds
// rx_ready until it sees rx_clr, and checks the results against hand-computed
// expectations.
module tb_uart_rx_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] rx_data = '0;
    logic              rx_ready = 1'b0;
    logic              rx_clr;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [4:0]        count;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              ovf_clr = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    uart_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .rx_clr   (rx_clr),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    // Receiver model: present a byte, hold rx_ready until rx_clr, then drop it.
    task automatic send_byte(input logic [7:0] b, input logic with_clr);
        int waited;
        waited = 0;
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        ovf_clr  = with_clr;
        @(posedge clk);
        #1 ovf_clr = 1'b0;
        while (rx_clr !== 1'b1 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        vectors++;
        if (rx_clr !== 1'b1) begin
            $display("FAIL rx_clr_ack byte %h: got %b, want 1 within 20 cycles", b, rx_clr);
            miscompares++;
        end
        @(negedge clk);
        rx_ready = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (rx_clr !== 1'b0) begin
            $display("FAIL rx_clr_pulse byte %h: got %b, want 0 on second cycle", b, rx_clr);
            miscompares++;
        end
        @(posedge clk);
        #1;
    endtask

    // Consumer model: check the head byte, then pop it.
    task automatic pop_byte(input logic [7:0] exp);
        @(negedge clk);
        vectors++;
        if (m_valid !== 1'b1 || m_data !== exp) begin
            $display("FAIL pop_data: got valid=%b data=%h, want valid=1 data=%h", m_valid, m_data, exp);
            miscompares++;
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (rx_clr !== 1'b0 || m_valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0) begin
            $display("FAIL reset_flags: got rx_clr=%b m_valid=%b empty=%b full=%b, want 0 0 1 0",
                     rx_clr, m_valid, empty, full);
            miscompares++;
        end
        vectors++;
        if (count !== 5'd0 || overflow !== 1'b0) begin
            $display("FAIL reset_count: got count=%0d overflow=%b, want 0 0", count, overflow);
            miscompares++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        send_byte(8'hA5, 1'b0);
        @(negedge clk);
        vectors++;
        if (count !== 5'd1 || m_valid !== 1'b1 || m_data !== 8'hA5) begin
            $display("FAIL single_store: got count=%0d valid=%b data=%h, want 1 1 a5", count, m_valid, m_data);
            miscompares++;
        end
        pop_byte(8'hA5);
        vectors++;
        if (count !== 5'd0 || empty !== 1'b1) begin
            $display("FAIL single_pop: got count=%0d empty=%b, want 0 1", count, empty);
            miscompares++;
        end
    endtask

    task automatic test_level_held();
        int waited;
        waited = 0;
        @(negedge clk);
        rx_data  = 8'h3C;
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        while (rx_clr !== 1'b1 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        vectors++;
        if (rx_clr !== 1'b1) begin
            $display("FAIL level_ack: got rx_clr=%b, want 1", rx_clr);
            miscompares++;
        end
        repeat (10) @(negedge clk);
        vectors++;
        if (count !== 5'd1 || rx_clr !== 1'b0) begin
            $display("FAIL level_dup: got count=%0d rx_clr=%b, want 1 0", count, rx_clr);
            miscompares++;
        end
        rx_ready = 1'b0;
        repeat (2) @(negedge clk);
        pop_byte(8'h3C);
        vectors++;
        if (empty !== 1'b1) begin
            $display("FAIL level_empty: got empty=%b, want 1", empty);
            miscompares++;
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 1'b0);
        @(negedge clk);
        vectors++;
        if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
            $display("FAIL fill_full: got full=%b count=%0d ovf=%b, want 1 16 0", full, count, overflow);
            miscompares++;
        end
        send_byte(8'hFF, 1'b0);
        @(negedge clk);
        vectors++;
        if (overflow !== 1'b1 || count !== 5'd16) begin
            $display("FAIL fill_drop: got ovf=%b count=%0d, want 1 16", overflow, count);
            miscompares++;
        end
        for (int i = 0; i < DEPTH; i++) pop_byte(8'(i));
        vectors++;
        if (empty !== 1'b1 || m_valid !== 1'b0) begin
            $display("FAIL fill_drain: got empty=%b valid=%b, want 1 0", empty, m_valid);
            miscompares++;
        end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        vectors++;
        if (overflow !== 1'b0) begin
            $display("FAIL ovf_clear: got %b, want 0", overflow);
            miscompares++;
        end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] base;
        logic [7:0] extra;
        for (int r = 0; r < 2; r++) begin
            base  = (r == 0) ? 8'h10 : 8'h40;
            extra = (r == 0) ? 8'h55 : 8'hAA;
            for (int i = 0; i < DEPTH; i++) send_byte(base + 8'(i), 1'b0);
            @(negedge clk);
            vectors++;
            if (full !== 1'b1 || m_data !== base) begin
                $display("FAIL pp_full round %0d: got full=%b head=%h, want 1 %h", r, full, m_data, base);
                miscompares++;
            end
            rx_data  = extra;
            rx_ready = 1'b1;
            m_ready  = 1'b1;
            @(posedge clk);
            #1;
            vectors++;
            if (rx_clr !== 1'b1) begin
                $display("FAIL pp_ack round %0d: got rx_clr=%b, want 1", r, rx_clr);
                miscompares++;
            end
            @(negedge clk);
            m_ready  = 1'b0;
            rx_ready = 1'b0;
            vectors++;
            if (count !== 5'd16 || overflow !== 1'b0) begin
                $display("FAIL pp_count round %0d: got count=%0d ovf=%b, want 16 0", r, count, overflow);
                miscompares++;
            end
            repeat (2) @(posedge clk);
            for (int i = 1; i < DEPTH; i++) pop_byte(base + 8'(i));
            pop_byte(extra);
            vectors++;
            if (empty !== 1'b1) begin
                $display("FAIL pp_drain round %0d: got empty=%b, want 1", r, empty);
                miscompares++;
            end
        end
    endtask

    task automatic test_reset_mid();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        @(negedge clk);
        rx_data  = 8'h77;
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (rx_clr !== 1'b1 || count !== 5'd4) begin
            $display("FAIL mid_ack: got rx_clr=%b count=%0d, want 1 4", rx_clr, count);
            miscompares++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (count !== 5'd0 || m_valid !== 1'b0 || rx_clr !== 1'b0) begin
            $display("FAIL mid_reset: got count=%0d valid=%b rx_clr=%b, want 0 0 0", count, m_valid, rx_clr);
            miscompares++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (count !== 5'd1 || rx_clr !== 1'b1) begin
            $display("FAIL mid_recapture: got count=%0d rx_clr=%b, want 1 1", count, rx_clr);
            miscompares++;
        end
        @(negedge clk);
        rx_ready = 1'b0;
        repeat (2) @(posedge clk);
        pop_byte(8'h77);
        for (int i = 0; i < DEPTH; i++) send_byte(8'h80 + 8'(i), 1'b0);
        send_byte(8'hEE, 1'b1);
        @(negedge clk);
        vectors++;
        if (overflow !== 1'b1 || count !== 5'd16) begin
            $display("FAIL ovf_set_wins: got ovf=%b count=%0d, want 1 16", overflow, count);
            miscompares++;
        end
        for (int i = 0; i < DEPTH; i++) pop_byte(8'h80 + 8'(i));
        vectors++;
        if (empty !== 1'b1) begin
            $display("FAIL ovf_drain: got empty=%b, want 1", empty);
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_level_held();
        test_fill_overflow();
        test_push_pop_full();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
